dcache_load_arbiter: RTL and testbench
======================================

// Module: dcache_load_arbiter
// PURPOSE
//  Shares the single dcache load-lookup port between NUM_MEM_FU memory FUs.
//  - Each FU presents is_load_request + dcache_addr each cycle. The arbiter picks one, drives the
//    dcache port, and returns the cache response only to the granted FU.
//  - Round-robin fairness. A granted FU that misses is held (locked) until it hits, so the dcache
//    fill completes for it; after MAX_HOLD miss cycles priority rotates anyway.
//  - Sits between the mem FU array and the dcache, one per load port.
// PARAMETERS
//  NUM_MEM_FU   2   number of requesting mem FUs (>=1)
//  MAX_HOLD     8   max consecutive miss cycles one FU holds the lock before forced rotation (>=1)
// PORTS
//  clock         in   1                  system clock
//  reset         in   1                  synchronous, active-high
//  fu_req        in   NUM_MEM_FU         per-FU is_load_request
//  fu_addr       in   D_ADDR[NUM_MEM_FU] per-FU dcache_addr
//  fu_grant      out  NUM_MEM_FU         one-hot (or zero): FU whose addr drives the dcache this cycle
//  fu_hit_data   out  CACHE_DATA[NUM_MEM_FU]  cache response routed to granted FU; '0 for all others
//  dcache_req    out  1                  a lookup is presented this cycle
//  dcache_addr   out  D_ADDR             address of the granted FU ('0 when !dcache_req)
//  dcache_data   in   CACHE_DATA         same-cycle dcache response (valid = hit)
//  hold_expired  out  1                  pulse: lock broken by MAX_HOLD timeout this cycle (perf/debug)
// BEHAVIOUR
//  - State: mode (ARB_FREE/ARB_LOCKED), rr_ptr [$clog2(NUM_MEM_FU)], holder idx, hold_cnt [$clog2(MAX_HOLD+1)].
//  - Reset (sync): mode=ARB_FREE, rr_ptr=0, holder=0, hold_cnt=0. While reset is high:
//    fu_grant=0, dcache_req=0, dcache_addr=0, fu_hit_data all 0, hold_expired=0.
//  - All outputs are combinational from state + inputs; zero-cycle latency, request to response in
//    the same cycle.
//  - ARB_FREE: grant the first requesting FU searching rr_ptr, rr_ptr+1, ... (mod NUM_MEM_FU). None -> no grant.
//  - ARB_LOCKED: grant holder if fu_req[holder]. If holder dropped its request (e.g. squashed):
//    unlock and, the same cycle, arbitrate as ARB_FREE starting from holder+1.
//  - fu_hit_data[g] = dcache_data for granted g; all other entries '0. dcache_data is ignored when
//    there is no grant.
//  - Next-state update with grant g:
//    - hit (dcache_data.valid): mode=ARB_FREE, rr_ptr=g+1 mod N, hold_cnt=0.
//    - miss and hold_cnt+1 < MAX_HOLD: mode=ARB_LOCKED, holder=g, hold_cnt++.
//    - miss and hold_cnt+1 == MAX_HOLD: mode=ARB_FREE, rr_ptr=g+1, hold_cnt=0, hold_expired=1 this
//      cycle. The FU keeps requesting and re-competes normally.
//    - no grant: mode=ARB_FREE, rr_ptr and hold_cnt unchanged (hold_cnt=0 if lock was dropped).
//  - A single requester is granted every cycle regardless of lock/rotation state.
//  - NUM_MEM_FU==1: rr_ptr tied to 0; lock/timeout logic still runs (hold_expired still pulses).
//  - rr_ptr wrap: N-1 -> 0. hold_cnt never exceeds MAX_HOLD-1 at a clock edge.
//  - Reset asserted mid-lock: lock discarded, next cycle after reset behaves as fresh ARB_FREE from FU 0.
//  - No ready/valid back-pressure to FUs: an ungranted FU simply keeps its request up. Mem FUs
//    treat fu_hit_data[i] exactly as their cache_hit_data input.
// STRUCTURE
//  - sys_defs.svh: add typedef enum logic {ARB_FREE, ARB_LOCKED} DCACHE_ARB_MODE.
//    Reuse D_ADDR and CACHE_DATA. Add `NUM_MEM_FU / `DCACHE_ARB_MAX_HOLD defaults there.
//  - Sub-module rr_picker #(N): in req[N], start_idx -> out gnt_onehot[N], gnt_idx, gnt_valid
//    (pure combinational rotate + priority encode). Everything else stays in this module.
// TESTING
//  1. Reset with fu_req=2'b11 held high -> all outputs 0. First post-reset cycle grants FU0.
//  2. N=2, both req, dcache hits every cycle -> grants alternate FU0,FU1,FU0,...; fu_hit_data only on
//     the granted index.
//  3. N=2, FU1 misses 3 cycles then hits, FU0 requesting throughout -> FU1 granted 4 consecutive
//     cycles, then FU0 granted; hold_expired stays 0.
//  4. MAX_HOLD=8, FU0 misses forever, FU1 requesting:
//     - FU0 granted cycles 0..7, hold_expired=1 in cycle 7, FU1 granted in cycle 8.
//  5. FU0 locked after a miss, then drops fu_req while FU1 requests -> FU1 granted that same cycle;
//     mode returns to FREE (LOCKED on FU1 if it misses).
//  6. Reset asserted during FU1's lock (hold_cnt=3) -> next cycle, both requesting, FU0 granted and
//     hold_cnt restarts from 0.

Source files
------------

// File: rtl/dcache_load_arbiter_pkg.sv
// Shared types and defaults for the dcache load-port arbiter.
// Address/data shapes match the dcache lookup port.
package dcache_load_arbiter_pkg;

  localparam int NUM_MEM_FU_DEF      = 2;
  localparam int DCACHE_ARB_MAX_HOLD = 8;
  localparam int D_ADDR_W            = 16;
  localparam int CACHE_DATA_W        = 32;

  typedef logic [D_ADDR_W-1:0] D_ADDR;

  typedef struct packed {
    logic                    valid;
    logic [CACHE_DATA_W-1:0] data;
  } CACHE_DATA;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } DCACHE_ARB_MODE;

endpackage

// File: rtl/dcache_load_arbiter_if.sv
// Bundle between the mem FU array, the arbiter and one dcache load port.
// master = arbiter side, slave = FU array / dcache side.
interface dcache_load_arbiter_if
  import dcache_load_arbiter_pkg::*;
#(
  parameter int N = NUM_MEM_FU_DEF
) ();

  logic      [N-1:0] fu_req;
  D_ADDR     [N-1:0] fu_addr;
  logic      [N-1:0] fu_grant;
  CACHE_DATA [N-1:0] fu_hit_data;
  logic              dcache_req;
  D_ADDR             dcache_addr;
  CACHE_DATA         dcache_data;
  logic              hold_expired;

  modport master (
    input  fu_req,
    input  fu_addr,
    input  dcache_data,
    output fu_grant,
    output fu_hit_data,
    output dcache_req,
    output dcache_addr,
    output hold_expired
  );

  modport slave (
    output fu_req,
    output fu_addr,
    output dcache_data,
    input  fu_grant,
    input  fu_hit_data,
    input  dcache_req,
    input  dcache_addr,
    input  hold_expired
  );

endinterface

// File: rtl/dcache_load_arbiter_rr_picker.sv
// Rotating priority encoder: first set req bit at or after start_idx.
// Purely combinational.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start_idx,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  always_comb begin
    int i;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    i          = 0;
    for (int k = 0; k < N; k++) begin
      i = (int'(start_idx) + k) % N;
      if (!gnt_valid && req[i]) begin
        gnt_valid     = 1'b1;
        gnt_idx       = IW'(i);
        gnt_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_load_arbiter.sv
// Round-robin arbiter for one dcache load port; a missing FU keeps
// the port until it hits or MAX_HOLD miss cycles elapse.
module dcache_load_arbiter
  import dcache_load_arbiter_pkg::*;
#(
  parameter int NUM_MEM_FU = NUM_MEM_FU_DEF,
  parameter int MAX_HOLD   = DCACHE_ARB_MAX_HOLD
) (
  input  logic                  clock,
  input  logic                  reset,
  dcache_load_arbiter_if.master bus
);

  localparam int IW = (NUM_MEM_FU > 1) ? $clog2(NUM_MEM_FU) : 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  DCACHE_ARB_MODE mode, mode_nx;

  logic [IW-1:0] rr_ptr, rr_nx;
  logic [IW-1:0] holder, holder_nx;
  logic [CW-1:0] hold_cnt, cnt_nx;
  logic [CW-1:0] cnt_base;

  logic [IW-1:0]         start_idx;
  logic [IW-1:0]         pick_idx;
  logic [NUM_MEM_FU-1:0] pick_oh;
  logic                  pick_v;

  logic [IW-1:0]         g_idx;
  logic                  g_v;
  logic                  keep;
  logic                  hit;
  logic                  expire;
  logic                  out_en;
  logic [NUM_MEM_FU-1:0] grant;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    if (NUM_MEM_FU == 1) return '0;
    if (int'(i) == NUM_MEM_FU - 1) return '0;
    return IW'(int'(i) + 1);
  endfunction

  rr_picker #(
    .N  (NUM_MEM_FU),
    .IW (IW)
  ) u_pick (
    .req        (bus.fu_req),
    .start_idx  (start_idx),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx),
    .gnt_valid  (pick_v)
  );

  // A dropped lock rearbitrates this cycle, starting past the holder
  always_comb begin
    keep      = (mode == ARB_LOCKED) && bus.fu_req[holder];
    start_idx = rr_ptr;
    if (mode == ARB_LOCKED && !keep)
      start_idx = nxt(holder);
    g_v      = keep | pick_v;
    g_idx    = keep ? holder : pick_idx;
    hit      = g_v && bus.dcache_data.valid;
    cnt_base = keep ? hold_cnt : '0;
    expire   = g_v && !hit &&
               (int'(cnt_base) + 1 >= MAX_HOLD);
  end

  always_comb begin
    mode_nx   = ARB_FREE;
    rr_nx     = rr_ptr;
    holder_nx = holder;
    cnt_nx    = '0;
    unique case (1'b1)
      !g_v: ;
      hit:    rr_nx = nxt(g_idx);
      expire: rr_nx = nxt(g_idx);
      default: begin
        mode_nx   = ARB_LOCKED;
        holder_nx = g_idx;
        cnt_nx    = CW'(int'(cnt_base) + 1);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode     <= ARB_FREE;
      rr_ptr   <= '0;
      holder   <= '0;
      hold_cnt <= '0;
    end else begin
      mode     <= mode_nx;
      rr_ptr   <= rr_nx;
      holder   <= holder_nx;
      hold_cnt <= cnt_nx;
    end
  end

  always_comb begin
    out_en = !reset;
    grant  = '0;
    for (int i = 0; i < NUM_MEM_FU; i++) begin
      if (keep)
        grant[i] = out_en && (holder == IW'(i));
      else
        grant[i] = out_en && pick_oh[i];
    end
  end

  always_comb begin
    bus.fu_grant    = grant;
    bus.fu_hit_data = '0;
    for (int i = 0; i < NUM_MEM_FU; i++) begin
      if (grant[i])
        bus.fu_hit_data[i] = bus.dcache_data;
    end
    bus.dcache_req   = out_en && g_v;
    bus.dcache_addr  = '0;
    if (out_en && g_v)
      bus.dcache_addr = bus.fu_addr[g_idx];
    bus.hold_expired = out_en && expire;
  end

endmodule

// File: tb/tb_dcache_load_arbiter.sv
// Scenario bench for dcache_load_arbiter (N=2, MAX_HOLD=8).
// Expected grants come from hand-derived stimulus tables.
module tb_dcache_load_arbiter;
  import dcache_load_arbiter_pkg::*;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   step;

  dcache_load_arbiter_if #(.N(2)) bus ();

  dcache_load_arbiter #(
    .NUM_MEM_FU (2),
    .MAX_HOLD   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] g;
    logic       ex;
    logic       rq;
    D_ADDR      a;
    CACHE_DATA  h0;
    CACHE_DATA  h1;
  } exp_t;

  exp_t sbq[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s@%0d got=%h exp=%h", tag, step, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] req,
                     input logic hitv, input logic [1:0] eg,
                     input logic eex);
    exp_t e;
    exp_t x;
    reset                  = r;
    bus.fu_req             = req;
    bus.fu_addr[0]         = D_ADDR'($urandom);
    bus.fu_addr[1]         = D_ADDR'($urandom);
    bus.dcache_data.valid  = hitv;
    bus.dcache_data.data   = $urandom;
    e.g  = r ? 2'b00 : eg;
    e.ex = r ? 1'b0 : eex;
    e.rq = |e.g;
    e.a  = e.g[0] ? bus.fu_addr[0] :
           e.g[1] ? bus.fu_addr[1] : '0;
    e.h0 = e.g[0] ? bus.dcache_data : '0;
    e.h1 = e.g[1] ? bus.dcache_data : '0;
    sbq.push_back(e);
    @(negedge clock);
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty@%0d got=0 exp=1", step);
    end else begin
      x = sbq.pop_front();
      chk("grant", 64'(bus.fu_grant), 64'(x.g));
      chk("expired", 64'(bus.hold_expired), 64'(x.ex));
      chk("dc_req", 64'(bus.dcache_req), 64'(x.rq));
      chk("dc_addr", 64'(bus.dcache_addr), 64'(x.a));
      chk("hit0", 64'(bus.fu_hit_data[0]), 64'(x.h0));
      chk("hit1", 64'(bus.fu_hit_data[1]), 64'(x.h1));
    end
    step++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    step    = 0;
    reset   = 1'b1;
    bus.fu_req      = '0;
    bus.fu_addr     = '0;
    bus.dcache_data = '0;
    @(posedge clock);
    #1;

    // reset with both requesting, then FU0 first
    cyc(1, 2'b11, 1, 2'b00, 0);
    cyc(1, 2'b11, 1, 2'b00, 0);
    cyc(0, 2'b11, 1, 2'b01, 0);

    // alternation on hits
    cyc(0, 2'b11, 1, 2'b10, 0);
    cyc(0, 2'b11, 1, 2'b01, 0);
    cyc(0, 2'b11, 1, 2'b10, 0);
    cyc(0, 2'b11, 1, 2'b01, 0);

    // FU1 misses 3 then hits, then FU0
    cyc(0, 2'b11, 0, 2'b10, 0);
    cyc(0, 2'b11, 0, 2'b10, 0);
    cyc(0, 2'b11, 0, 2'b10, 0);
    cyc(0, 2'b11, 1, 2'b10, 0);
    cyc(0, 2'b11, 1, 2'b01, 0);

    // FU1 hit moves pointer to FU0; FU0 then misses to timeout
    cyc(0, 2'b11, 1, 2'b10, 0);
    for (int k = 0; k < 8; k++)
      cyc(0, 2'b11, 0, 2'b01, k == 7);
    cyc(0, 2'b11, 1, 2'b10, 0);

    // idle and single requesters
    cyc(0, 2'b00, 1, 2'b00, 0);
    cyc(0, 2'b10, 1, 2'b10, 0);
    cyc(0, 2'b01, 0, 2'b01, 0);

    // FU0 drops while locked: FU1 same cycle, then locks
    cyc(0, 2'b10, 0, 2'b10, 0);
    cyc(0, 2'b11, 0, 2'b10, 0);
    cyc(0, 2'b11, 0, 2'b10, 0);

    // reset mid-lock: fresh arbitration and full hold budget
    cyc(1, 2'b11, 0, 2'b00, 0);
    for (int k = 0; k < 8; k++)
      cyc(0, 2'b11, 0, 2'b01, k == 7);
    cyc(0, 2'b11, 1, 2'b10, 0);

    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_left got=%0d exp=0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
